// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multicycle sequencer for the mini-CPU datapath.
// Steps fetch/decode/execute/memory/writeback, drives the ALU op code,
// mux selects and write strobes, and parks in TRAP on anything it cannot run.
module multicycle_ctrl #(
    parameter int xlen = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic        adr_src,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic        retire,
    output logic        trap
);
    // Load/store width is tied to the datapath: ld/sd on 64-bit, lw/sw on 32-bit.
    localparam logic [2:0] LS_F3 = (xlen == 64) ? 3'b011 : 3'b010;

    localparam logic [6:0] OP_LOAD   = 7'b0000011,
                           OP_STORE  = 7'b0100011,
                           OP_RTYPE  = 7'b0110011,
                           OP_ITYPE  = 7'b0010011,
                           OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_AND = 3'b000,
                           ALU_OR  = 3'b001,
                           ALU_ADD = 3'b010,
                           ALU_SUB = 3'b110,
                           ALU_SLT = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000,
                           F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BEQ,
        S_TRAP
    } state_t;

    state_t     state_q, state_d;
    logic       trap_q;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign funct7        = instr[31:25];
    // Register numbers and immediates belong to the datapath, not to sequencing.
    assign unused_fields = ^{instr[24:15], instr[11:7]};

    // R-type: add/sub on f3=000 (f7 picks which), and/or/slt need f7=0.
    function automatic logic r_legal(input logic [2:0] f3, input logic [6:0] f7);
        case (f3)
            3'b000:                 r_legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
            3'b111, 3'b110, 3'b010: r_legal = (f7 == F7_ZERO);
            default:                r_legal = 1'b0;
        endcase
    endfunction

    // I-type ALU ops: funct7 bits are immediate, only funct3 matters.
    function automatic logic i_legal(input logic [2:0] f3);
        i_legal = (f3 == 3'b000) || (f3 == 3'b111) || (f3 == 3'b110) || (f3 == 3'b010);
    endfunction

    // Shared funct3 -> ALU op map; legality is settled in DECODE so the
    // default arm only ever sees f3=000.
    function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b111:  alu_op = ALU_AND;
            3'b110:  alu_op = ALU_OR;
            3'b010:  alu_op = ALU_SLT;
            default: alu_op = sub ? ALU_SUB : ALU_ADD;
        endcase
    endfunction

    // State register; reset abandons any in-flight access and restarts in FETCH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    // Sticky illegal-instruction flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    trap_q <= 1'b0;
        else if (state_d == S_TRAP) trap_q <= 1'b1;
    end

    // Next-state: memory states hold until mem_ready, DECODE dispatches on opcode.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD:   state_d = (funct3 == LS_F3) ? S_MEMADR : S_TRAP;
                    OP_STORE:  state_d = (funct3 == LS_F3) ? S_MEMADR : S_TRAP;
                    OP_RTYPE:  state_d = r_legal(funct3, funct7) ? S_EXECR : S_TRAP;
                    OP_ITYPE:  state_d = i_legal(funct3) ? S_EXECI : S_TRAP;
                    OP_BRANCH: state_d = (funct3 == 3'b000) ? S_BEQ : S_TRAP;
                    default:   state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // Output decode from state; reset forces every output to its idle value.
    always_comb begin
        alu_ctrl   = ALU_ADD;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        adr_src    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    // pc+4 path held for the whole fetch so selects never move mid-request
                    mem_req    = 1'b1;
                    alu_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                    retire     = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                    retire  = mem_ready;
                end
                S_EXECR: begin
                    alu_src_a = 2'b10;
                    alu_ctrl  = alu_op(funct3, funct7 == F7_ALT);
                end
                S_EXECI: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    alu_ctrl  = alu_op(funct3, 1'b0);
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    retire    = 1'b1;
                end
                S_BEQ: begin
                    alu_src_a = 2'b10;
                    alu_ctrl  = ALU_SUB;
                    pc_write  = zero;
                    retire    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign trap = trap_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-written memory-wait
// and reset sequences, then random instructions against a timing model.
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;
    logic [2:0]  alu_ctrl;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic        adr_src, mem_req, mem_we, ir_write, pc_write, reg_write, retire, trap;

    multicycle_ctrl #(.xlen(64)) dut (
        .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .adr_src(adr_src), .mem_req(mem_req), .mem_we(mem_we),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .retire(retire), .trap(trap)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] LS_F3 = 3'b011;

    int n_checks = 0;
    int n_fail   = 0;
    logic rdy [0:63];

    // per-instruction observations
    int o_cycles, o_ir, o_pcw, o_regw, o_wr, o_hs, o_req0, o_req1;
    int o_retire, o_trap_at, o_trap_bad, o_op;

    typedef struct {
        logic [31:0] ins;
        logic        z;
        bit          legal;
        int          cycles;
        int          regw;
        int          pcw;
        int          wr;
        int          op;
    } vec_t;

    typedef struct {
        bit legal;
        int cycles, regw, pcw, wr, hs, req0, req1, trap_at, op;
    } exp_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference timing: instruction class from the opcode/funct rules, cycle
    // counts from where the ready pattern lets each memory phase complete.
    function automatic exp_t model(input logic [31:0] ins, input logic z);
        exp_t e;
        int f, m, start, kind;
        logic [6:0] opc, f7;
        logic [2:0] f3;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
        e.legal = 0; e.cycles = 0; e.regw = 0; e.pcw = 1; e.wr = 0; e.hs = 1;
        e.req1 = 0; e.trap_at = -1; e.op = -1;
        f = 0;
        while (f < 63 && !rdy[f]) f++;
        e.req0 = f + 1;
        kind = 0;  // 0 illegal, 1 alu, 2 beq, 3 load, 4 store
        case (opc)
            7'h03: if (f3 == LS_F3) kind = 3;
            7'h23: if (f3 == LS_F3) kind = 4;
            7'h33: begin
                if (f3 == 3'd0 && f7 == 7'h00)      begin kind = 1; e.op = 2; end
                else if (f3 == 3'd0 && f7 == 7'h20) begin kind = 1; e.op = 6; end
                else if (f7 == 7'h00) begin
                    if (f3 == 3'd7)      begin kind = 1; e.op = 0; end
                    else if (f3 == 3'd6) begin kind = 1; e.op = 1; end
                    else if (f3 == 3'd2) begin kind = 1; e.op = 7; end
                end
            end
            7'h13: begin
                if (f3 == 3'd0)      begin kind = 1; e.op = 2; end
                else if (f3 == 3'd7) begin kind = 1; e.op = 0; end
                else if (f3 == 3'd6) begin kind = 1; e.op = 1; end
                else if (f3 == 3'd2) begin kind = 1; e.op = 7; end
            end
            7'h63: if (f3 == 3'd0) begin kind = 2; e.op = 6; end
            default: ;
        endcase
        case (kind)
            1: begin e.cycles = f + 4; e.regw = 1; end
            2: begin e.cycles = f + 3; e.pcw = 1 + int'(z); end
            3, 4: begin
                start = f + 3;
                m = start;
                while (m < 63 && !rdy[m]) m++;
                e.req1 = m - start + 1;
                e.hs = 2;
                e.op = 2;
                if (kind == 3) begin e.cycles = m + 2; e.regw = 1; end
                else           begin e.cycles = m + 1; e.wr = 1; end
            end
            default: e.trap_at = f + 2;
        endcase
        e.legal = (kind != 0);
        return e;
    endfunction

    // Random instruction drawn from legal classes plus a few illegal shapes.
    function automatic logic [31:0] gen();
        logic [31:0] ins;
        int k;
        ins = $urandom;
        k = $urandom_range(0, 9);
        case (k)
            0: begin ins[6:0] = 7'h33; ins[14:12] = 3'd0; ins[31:25] = 7'h00; end
            1: begin ins[6:0] = 7'h33; ins[14:12] = 3'd0; ins[31:25] = 7'h20; end
            2: begin
                ins[6:0] = 7'h33; ins[31:25] = 7'h00;
                case ($urandom_range(0, 2))
                    0: ins[14:12] = 3'd7;
                    1: ins[14:12] = 3'd6;
                    default: ins[14:12] = 3'd2;
                endcase
            end
            3: begin
                ins[6:0] = 7'h13;
                case ($urandom_range(0, 3))
                    0: ins[14:12] = 3'd0;
                    1: ins[14:12] = 3'd7;
                    2: ins[14:12] = 3'd6;
                    default: ins[14:12] = 3'd2;
                endcase
            end
            4: begin ins[6:0] = 7'h63; ins[14:12] = 3'd0; end
            5: begin ins[6:0] = 7'h03; ins[14:12] = LS_F3; end
            6: begin ins[6:0] = 7'h23; ins[14:12] = LS_F3; end
            7: ins[6:0] = 7'h7F;
            8: begin
                ins[6:0] = ($urandom_range(0, 1) != 0) ? 7'h33 : 7'h13;
                ins[31:25] = 7'h00;
                case ($urandom_range(0, 3))
                    0: ins[14:12] = 3'd1;
                    1: ins[14:12] = 3'd3;
                    2: ins[14:12] = 3'd4;
                    default: ins[14:12] = 3'd5;
                endcase
            end
            default: begin
                case ($urandom_range(0, 2))
                    0: begin ins[6:0] = 7'h03; ins[14:12] = 3'd2; end
                    1: begin ins[6:0] = 7'h23; ins[14:12] = 3'd2; end
                    default: begin ins[6:0] = 7'h63; ins[14:12] = 3'd1; end
                endcase
            end
        endcase
        return ins;
    endfunction

    // Called one tick after a rising edge with the DUT in FETCH; runs until
    // retire or the cycle budget, sampling outputs on the falling edge.
    task automatic run_instr(input logic [31:0] ins, input logic z, input int limit);
        bit done;
        done = 0;
        o_cycles = 0; o_ir = 0; o_pcw = 0; o_regw = 0; o_wr = 0; o_hs = 0;
        o_req0 = 0; o_req1 = 0; o_retire = 0; o_trap_at = -1; o_trap_bad = 0; o_op = -1;
        instr = ins;
        zero  = z;
        for (int c = 0; c < limit && !done; c++) begin
            mem_ready = rdy[c];
            @(negedge clk);
            if (ir_write)  o_ir++;
            if (pc_write)  o_pcw++;
            if (reg_write) o_regw++;
            if (mem_req && mem_ready) o_hs++;
            if (mem_req && mem_we && mem_ready) o_wr++;
            if (mem_req && !adr_src) o_req0++;
            if (mem_req && adr_src)  o_req1++;
            if (alu_src_a == 2'b10) o_op = int'(alu_ctrl);
            if (trap) begin
                if (o_trap_at < 0) o_trap_at = c;
                if (mem_req || mem_we || ir_write || pc_write || reg_write || retire) o_trap_bad++;
            end
            if (retire) begin
                o_retire++;
                o_cycles = c + 1;
                done = 1;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mem_ready = 1'b1;
        zero = 1'b1;
        #1;
        check("rst_mem_req", int'(mem_req), 0);
        check("rst_trap", int'(trap), 0);
        check("rst_alu_ctrl", int'(alu_ctrl), 2);
        check("rst_strobes", int'({mem_we, ir_write, pc_write, reg_write, retire, adr_src}), 0);
        check("rst_selects", int'({alu_src_a, alu_src_b, result_src}), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("post_rst_mem_req", int'(mem_req), 1);
    endtask

    task automatic compare(input string tag, input exp_t e);
        check({tag, "_retire"}, o_retire, e.legal ? 1 : 0);
        check({tag, "_ir_write"}, o_ir, 1);
        check({tag, "_pc_write"}, o_pcw, e.pcw);
        check({tag, "_reg_write"}, o_regw, e.regw);
        check({tag, "_mem_writes"}, o_wr, e.wr);
        check({tag, "_handshakes"}, o_hs, e.hs);
        check({tag, "_req_pc"}, o_req0, e.req0);
        check({tag, "_req_aluout"}, o_req1, e.req1);
        check({tag, "_trap_at"}, o_trap_at, e.trap_at);
        check({tag, "_trap_strobes"}, o_trap_bad, 0);
        if (e.legal) begin
            check({tag, "_cycles"}, o_cycles, e.cycles);
            check({tag, "_alu_ctrl"}, o_op, e.op);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv [11];
        exp_t e;
        logic [31:0] ins;
        logic z;

        tv[0]  = '{32'h003100B3, 1'b0, 1'b1, 4, 1, 1, 0, 2};   // add
        tv[1]  = '{32'h403100B3, 1'b0, 1'b1, 4, 1, 1, 0, 6};   // sub
        tv[2]  = '{32'h003120B3, 1'b0, 1'b1, 4, 1, 1, 0, 7};   // slt
        tv[3]  = '{32'h0FF17093, 1'b0, 1'b1, 4, 1, 1, 0, 0};   // andi
        tv[4]  = '{32'h00208463, 1'b1, 1'b1, 3, 0, 2, 0, 6};   // beq taken
        tv[5]  = '{32'h00208463, 1'b0, 1'b1, 3, 0, 1, 0, 6};   // beq not taken
        tv[6]  = '{32'h0000B083, 1'b0, 1'b1, 5, 1, 1, 0, 2};   // ld
        tv[7]  = '{32'h0020B023, 1'b0, 1'b1, 4, 0, 1, 1, 2};   // sd
        tv[8]  = '{32'h0000007F, 1'b0, 1'b0, 0, 0, 1, 0, -1};  // bad opcode
        tv[9]  = '{32'h003110B3, 1'b0, 1'b0, 0, 0, 1, 0, -1};  // R-type f3=001
        tv[10] = '{32'h0000A083, 1'b0, 1'b0, 0, 0, 1, 0, -1};  // lw on 64-bit

        #2;
        do_reset();

        // directed table, memory always ready
        for (int i = 0; i < 11; i++) begin
            for (int k = 0; k < 64; k++) rdy[k] = 1'b1;
            run_instr(tv[i].ins, tv[i].z, tv[i].legal ? tv[i].cycles + 2 : 6);
            check($sformatf("vec%0d_ir_write", i), o_ir, 1);
            check($sformatf("vec%0d_pc_write", i), o_pcw, tv[i].pcw);
            check($sformatf("vec%0d_reg_write", i), o_regw, tv[i].regw);
            check($sformatf("vec%0d_mem_writes", i), o_wr, tv[i].wr);
            check($sformatf("vec%0d_retire", i), o_retire, tv[i].legal ? 1 : 0);
            if (tv[i].legal) begin
                check($sformatf("vec%0d_cycles", i), o_cycles, tv[i].cycles);
                check($sformatf("vec%0d_alu_ctrl", i), o_op, tv[i].op);
                check($sformatf("vec%0d_trap", i), o_trap_at, -1);
            end else begin
                check($sformatf("vec%0d_trap_at", i), o_trap_at, 2);
                check($sformatf("vec%0d_trap_strobes", i), o_trap_bad, 0);
                do_reset();
            end
        end

        // ld with 3 fetch waits, ready ignored outside requests, 2 read waits
        for (int k = 0; k < 64; k++) rdy[k] = 1'b1;
        rdy[0] = 1'b0; rdy[1] = 1'b0; rdy[2] = 1'b0;
        rdy[6] = 1'b0; rdy[7] = 1'b0;
        run_instr(32'h0000B083, 1'b0, 14);
        check("ld_wait_cycles", o_cycles, 10);
        check("ld_wait_req_pc", o_req0, 4);
        check("ld_wait_req_aluout", o_req1, 3);
        check("ld_wait_ir_write", o_ir, 1);
        check("ld_wait_reg_write", o_regw, 1);
        check("ld_wait_retire", o_retire, 1);

        // sd interrupted by reset while waiting in the write phase
        instr = 32'h0020B023;
        zero = 1'b0;
        for (int c = 0; c < 4; c++) begin
            mem_ready = (c == 0);
            @(negedge clk);
            if (c < 3) begin
                @(posedge clk);
                #1;
            end
        end
        check("sd_wait_mem_we", int'(mem_we), 1);
        check("sd_wait_adr_src", int'(adr_src), 1);
        check("sd_wait_retire", int'(retire), 0);
        #1 rst = 1'b1;
        #1;
        check("sd_rst_mem_we", int'(mem_we), 0);
        check("sd_rst_mem_req", int'(mem_req), 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_ready = 1'b0;
            @(negedge clk);
            check($sformatf("sd_after_rst_fetch%0d", c),
                  int'({mem_req, mem_we, adr_src}), 4);
            @(posedge clk);
            #1;
        end
        for (int k = 0; k < 64; k++) rdy[k] = 1'b1;
        run_instr(32'h003100B3, 1'b0, 6);
        check("restart_add_cycles", o_cycles, 4);
        check("restart_add_reg_write", o_regw, 1);

        // random instructions, random memory latency
        for (int n = 0; n < 40; n++) begin
            ins = gen();
            z = 1'($urandom_range(0, 1));
            for (int k = 0; k < 64; k++) rdy[k] = (k >= 40) ? 1'b1 : ($urandom_range(0, 2) != 0);
            e = model(ins, z);
            run_instr(ins, z, e.legal ? e.cycles + 2 : e.trap_at + 4);
            compare($sformatf("rnd%0d_%08h", n, ins), e);
            if (!e.legal) do_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
